// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: op encoding and the default datapath width,
// imported by the ALU, its interface and the decoder/control unit.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOR  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_SLTU = 3'd7
  } aluOp_e;

endpackage

// File: rtl/mips_alu_if.sv
// Execute-stage ALU bus: operands and op in, registered result and flags out.
interface mips_alu_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic [WIDTH-1:0] aluOut;
    logic             zero;
    logic             overflow;

    modport master (
        output A, B, op,
        input  aluOut, zero, overflow
    );

    modport slave (
        input  A, B, op,
        output aluOut, zero, overflow
    );
endinterface

// File: rtl/mips_alu_addsub.sv
// Combinational shared adder/subtractor: sum = a + (b ^ {sub}) + sub,
// with carry-out and signed overflow of that operation.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow
);
    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   full;

    assign bEff     = b ^ {WIDTH{sub}};
    assign full     = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub};
    assign sum      = full[WIDTH-1:0];
    assign carryOut = full[WIDTH];
    // Overflow on the effective operands covers both ADD and SUB rules.
    assign overflow = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/mips_alu.sv
// Registered execute-stage ALU: eight ops, one-cycle latency, zero and
// signed-overflow flags registered alongside the result.
module mips_alu import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic       clk,
    input logic       rst,
    mips_alu_if.slave bus
);
    aluOp_e           opSel;
    logic             isSub;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
    logic             addOvf;
    logic [WIDTH-1:0] resNext;
    logic             ovfNext;
    logic [WIDTH-1:0] aluOut_p1;
    logic             zero_p1;
    logic             ovf_p1;

    assign opSel = aluOp_e'(bus.op);
    // Everything except ADD uses the subtract path, including both compares.
    assign isSub = (opSel != ALU_ADD);

    alu_addsub #(.WIDTH(WIDTH)) addsub (
        .a        (bus.A),
        .b        (bus.B),
        .sub      (isSub),
        .sum      (sum),
        .carryOut (carryOut),
        .overflow (addOvf)
    );

    always_comb begin
        resNext = '0;
        ovfNext = 1'b0;
        case (opSel)
            ALU_ADD:  begin resNext = sum; ovfNext = addOvf; end
            ALU_SUB:  begin resNext = sum; ovfNext = addOvf; end
            ALU_AND:  resNext = bus.A & bus.B;
            ALU_OR:   resNext = bus.A | bus.B;
            ALU_XOR:  resNext = bus.A ^ bus.B;
            ALU_NOR:  resNext = ~(bus.A | bus.B);
            // Sign of the difference corrected by overflow stays right when A-B wraps.
            ALU_SLT:  resNext = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ addOvf};
            ALU_SLTU: resNext = {{(WIDTH-1){1'b0}}, ~carryOut};
            default:  resNext = '0;
        endcase
    end

    // ---- stage p1: EX/MEM output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluOut_p1 <= '0;
            zero_p1   <= 1'b1;
            ovf_p1    <= 1'b0;
        end else begin
            aluOut_p1 <= resNext;
            zero_p1   <= (resNext == '0);
            ovf_p1    <= ovfNext;
        end
    end

    assign bus.aluOut   = aluOut_p1;
    assign bus.zero     = zero_p1;
    assign bus.overflow = ovf_p1;
endmodule

// File: tb/tb_mips_alu.sv
// Directed scoreboard bench for mips_alu: expected results are queued when
// operands are driven and compared one rising edge later.
module tb_mips_alu;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    mips_alu_if bus ();

    mips_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".out"},  bus.aluOut, 32'd0);
        check({tag, ".zero"}, {31'd0, bus.zero}, 32'd1);
        check({tag, ".ovf"},  {31'd0, bus.overflow}, 32'd0);
    endtask

    task automatic popCheck();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".out"},  bus.aluOut, e.out);
            check({e.tag, ".zero"}, {31'd0, bus.zero}, {31'd0, (e.out == 32'd0)});
            check({e.tag, ".ovf"},  {31'd0, bus.overflow}, {31'd0, e.ovf});
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                        input logic [31:0] expOut, input logic expOvf, input string tag);
        @(negedge clk);
        bus.A  = a;
        bus.B  = b;
        bus.op = o;
        sb.push_back('{tag, expOut, expOvf});
        @(posedge clk);
        #1;
        popCheck();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.A  = 32'hDEADBEEF;
        bus.B  = 32'h12345678;
        bus.op = 3'd4;
        #2;
        checkReset("reset_initial");

        @(negedge clk);
        rst = 1'b0;

        // op sweep, A=6000 B=5000
        step(32'd6000, 32'd5000, ALU_ADD,  32'd11000,     1'b0, "sweep_add");
        step(32'd6000, 32'd5000, ALU_SUB,  32'd1000,      1'b0, "sweep_sub");
        step(32'd6000, 32'd5000, ALU_AND,  32'd4864,      1'b0, "sweep_and");
        step(32'd6000, 32'd5000, ALU_OR,   32'd6136,      1'b0, "sweep_or");
        step(32'd6000, 32'd5000, ALU_XOR,  32'd1272,      1'b0, "sweep_xor");
        step(32'd6000, 32'd5000, ALU_NOR,  32'hFFFFE807,  1'b0, "sweep_nor");
        step(32'd6000, 32'd5000, ALU_SLT,  32'd0,         1'b0, "sweep_slt");
        step(32'd6000, 32'd5000, ALU_SLTU, 32'd0,         1'b0, "sweep_sltu");

        // swapped operands
        step(32'd5000, 32'd6000, ALU_SUB,  32'hFFFFFC18,  1'b0, "swap_sub");
        step(32'd5000, 32'd6000, ALU_SLT,  32'd1,         1'b0, "swap_slt");
        step(32'd5000, 32'd6000, ALU_SLTU, 32'd1,         1'b0, "swap_sltu");

        // signed vs unsigned compare
        step(32'hFFFFFFFF, 32'd1, ALU_SLT,  32'd1, 1'b0, "sgn_slt");
        step(32'hFFFFFFFF, 32'd1, ALU_SLTU, 32'd0, 1'b0, "sgn_sltu");

        // overflow and wrap boundaries
        step(32'h7FFFFFFF, 32'd1,         ALU_ADD,  32'h80000000, 1'b1, "ovf_add");
        step(32'h80000000, 32'd1,         ALU_SUB,  32'h7FFFFFFF, 1'b1, "ovf_sub");
        step(32'h80000000, 32'd1,         ALU_SLT,  32'd1,        1'b0, "ovf_slt");
        step(32'h7FFFFFFF, 32'hFFFFFFFF,  ALU_SUB,  32'h80000000, 1'b1, "ovf_sub_neg");
        step(32'hFFFFFFFF, 32'd1,         ALU_ADD,  32'd0,        1'b0, "wrap_add_zero");
        step(32'd0,        32'hFFFFFFFF,  ALU_SLTU, 32'd1,        1'b0, "sltu_max");
        step(32'h80000000, 32'h80000000,  ALU_ADD,  32'd0,        1'b1, "ovf_add_zero");

        // zero flag, then back-to-back different ops
        step(32'd1234, 32'd1234, ALU_SUB, 32'd0,        1'b0, "zero_sub");
        step(32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND, 32'h00F000F0, 1'b0, "b2b_and");
        step(32'hF0F0F0F0, 32'h0FF00FF0, ALU_XOR, 32'hFF00FF00, 1'b0, "b2b_xor");
        step(32'd100,      32'd250,      ALU_ADD, 32'd350,      1'b0, "b2b_add");

        // outputs hold while inputs change between edges
        bus.A  = 32'h0;
        bus.B  = 32'h0;
        bus.op = ALU_NOR;
        #3;
        check("hold.out",  bus.aluOut, 32'd350);
        check("hold.zero", {31'd0, bus.zero}, 32'd0);

        // asynchronous reset mid-stream discards the in-flight result
        rst = 1'b1;
        #1;
        checkReset("reset_async");
        @(negedge clk);
        bus.A  = 32'd7;
        bus.B  = 32'd9;
        bus.op = ALU_ADD;
        @(posedge clk);
        #1;
        checkReset("reset_held");

        // release: the next edge captures the current inputs
        @(negedge clk);
        rst    = 1'b0;
        bus.A  = 32'd3;
        bus.B  = 32'd4;
        bus.op = ALU_OR;
        sb.push_back('{"release_or", 32'd7, 1'b0});
        @(posedge clk);
        #1;
        popCheck();

        step(32'd3, 32'd4, ALU_SLTU, 32'd1, 1'b0, "post_reset_sltu");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_alu.md
# mips_alu

Registered 32-bit integer ALU for the MIPS datapath execute stage. It computes one of eight arithmetic, logical or compare functions on operands A and B, selected by a 3-bit op code. The result and status flags are registered on the clock edge and are available to the EX/MEM boundary.

## Interface
Parameters:
- WIDTH, 32, operand and result width; all rules below are stated for WIDTH=32.

Ports:
- clk  input  1  single system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A, two's complement or unsigned depending on op.
- B  input  WIDTH  operand B.
- op  input  3  function select.
- aluOut  output  WIDTH  registered result.
- zero  output  1  registered; 1 when the next-state result equals 0.
- overflow  output  1  registered; signed overflow for ADD and SUB, 0 for all other ops.

## Operation
Op encoding, fixed:
- 0 ADD: A + B, modulo 2^32.
- 1 SUB: A - B, modulo 2^32.
- 2 AND: A & B.
- 3 OR: A | B.
- 4 XOR: A ^ B.
- 5 NOR: ~(A | B).
- 6 SLT: 1 if $signed(A) < $signed(B), else 0. The result is zero-extended to 32 bits.
- 7 SLTU: 1 if A < B as unsigned, else 0. The result is zero-extended.

Arithmetic rules:
- ADD and SUB share one adder: sum = A + (B ^ {32{sub}}) + sub.
- ADD overflow = (A[31]==B[31]) && (sum[31]!=A[31]).
- SUB overflow = (A[31]!=B[31]) && (sum[31]!=A[31]).
- SLT = sum_sub[31] XOR sub_overflow. The comparison is correct even when the subtraction wraps.
- SLTU = NOT carry-out of A + ~B + 1.
- Overflow never suppresses the result write. The wrapped value is still registered. The flag is informational only, and trap handling lives outside this block.
- zero is computed from the combinational result before the register, so it always matches aluOut in the same cycle.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at rising edge N appear on aluOut, zero and overflow after edge N.
- Throughput is one operation per cycle. There is no handshake and no stall input.
- Asserting rst clears all outputs immediately, without waiting for a clock edge: aluOut=0, zero=1, overflow=0.
- Deasserting rst has effect at the next rising edge, which captures the current inputs.
- If rst is asserted mid-stream, the in-flight result is discarded. No partial state survives reset.
- Outputs hold their value between edges even if the inputs change.

## Structure
- Shared package alu_pkg contains:
  - the op enum: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_NOR=5, ALU_SLT=6, ALU_SLTU=7;
  - the width constant, used by the decoder and control unit.
- Sub-module alu_addsub: a purely combinational shared add/subtract unit with outputs sum, carry-out and signed overflow.
- Top level contains the result mux, the zero detect, and the output register with asynchronous reset.

## Test plan
- Reset behaviour: assert rst with arbitrary inputs -> aluOut=0, zero=1, overflow=0 immediately, with no clock edge needed.
- Op sweep with A=6000, B=5000, op stepped 0..7 once per cycle. Required results, one edge after each op is applied:
  - ADD 11000, SUB 1000, AND 4864, OR 6136, XOR 1272.
  - NOR 0xFFFFE807, SLT 0, SLTU 0.
- Swapped operands A=5000, B=6000:
  - SUB -> 0xFFFFFC18 (-1000);
  - SLT -> 1, SLTU -> 1.
- Signed versus unsigned compare with A=0xFFFFFFFF, B=1 -> SLT=1, SLTU=0.
- Overflow cases:
  - ADD 0x7FFFFFFF+1 -> aluOut=0x80000000, overflow=1;
  - SUB 0x80000000-1 -> aluOut=0x7FFFFFFF, overflow=1;
  - SLT 0x80000000 vs 1 -> 1.
- Zero flag and latency:
  - SUB A=B=1234 -> aluOut=0, zero=1.
  - Back-to-back different ops each produce the correct result exactly one edge later.
  - Changing the inputs between edges leaves the outputs unchanged.
